// File: rtl/muldiv_iter.sv
// ============================================================================
// muldiv_iter : iterative shift-add multiplier / restoring divider, HI/LO regs
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic             op_unsigned_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             kill_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [2:0] c_OP_MUL  = 3'd1;
    localparam logic [2:0] c_OP_MADD = 3'd2;
    localparam logic [2:0] c_OP_MSUB = 3'd3;
    localparam logic [2:0] c_OP_DIV  = 3'd4;
    localparam logic [2:0] c_OP_MTHI = 3'd5;
    localparam logic [2:0] c_OP_MTLO = 3'd6;

    localparam int            CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] c_MUL_LAST = CW'(WIDTH / MUL_BITS - 1);
    localparam logic [CW-1:0] c_DIV_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [2:0]           op_q;
    logic                 neg_q;
    logic                 rem_neg_q;
    logic                 bzero_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 dbz_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                      w_a_neg;
    logic                      w_b_neg;
    logic [WIDTH-1:0]          w_a_mag;
    logic [WIDTH-1:0]          w_b_mag;
    logic [WIDTH+MUL_BITS-1:0] w_pp;
    logic [WIDTH+MUL_BITS-1:0] w_mul_sum;
    logic [2*WIDTH-1:0]        w_prod_mul;
    logic [WIDTH:0]            w_div_trial;
    logic [2*WIDTH-1:0]        w_prod_div;
    logic [2*WIDTH-1:0]        w_product;
    logic [WIDTH-1:0]          w_quo;
    logic [WIDTH-1:0]          w_rem;
    logic [2*WIDTH-1:0]        w_result;

    always_comb begin
        w_a_neg = !op_unsigned_i && a_i[WIDTH-1];
        w_b_neg = !op_unsigned_i && b_i[WIDTH-1];
        w_a_mag = w_a_neg ? -a_i : a_i;
        w_b_mag = w_b_neg ? -b_i : b_i;
    end

    // prod_q = {partial sum, multiplier bits not yet consumed}; retire MUL_BITS per step
    always_comb begin
        w_pp = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (prod_q[i]) begin
                w_pp = w_pp + ({{MUL_BITS{1'b0}}, mcand_q} << i);
            end
        end
        w_mul_sum  = {{MUL_BITS{1'b0}}, prod_q[2*WIDTH-1:WIDTH]} + w_pp;
        w_prod_mul = {w_mul_sum, prod_q[WIDTH-1:MUL_BITS]};
    end

    // prod_q = {remainder, dividend shifting out / quotient shifting in}
    always_comb begin
        w_div_trial = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]} - {1'b0, mcand_q};
        if (!w_div_trial[WIDTH]) begin
            w_prod_div = {w_div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end else begin
            w_prod_div = {prod_q[2*WIDTH-2:0], 1'b0};
        end
    end

    // A zero divisor leaves |a| in the remainder, so the remainder fix-up restores a
    always_comb begin
        w_product = neg_q ? -prod_q : prod_q;
        w_quo     = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        w_rem     = rem_neg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
        case (op_q)
            c_OP_MADD: w_result = {hi_q, lo_q} + w_product;
            c_OP_MSUB: w_result = {hi_q, lo_q} - w_product;
            c_OP_DIV:  w_result = {w_rem, bzero_q ? {WIDTH{1'b1}} : w_quo};
            default:   w_result = w_product;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            bzero_q   <= 1'b0;
            mcand_q   <= '0;
            prod_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i && !kill_i) begin
                        case (op_i)
                            c_OP_MUL, c_OP_MADD, c_OP_MSUB, c_OP_DIV: begin
                                state_q   <= S_CALC;
                                busy_q    <= 1'b1;
                                dbz_q     <= 1'b0;
                                op_q      <= op_i;
                                neg_q     <= w_a_neg ^ w_b_neg;
                                rem_neg_q <= w_a_neg;
                                bzero_q   <= (b_i == '0);
                                cnt_q     <= (op_i == c_OP_DIV) ? c_DIV_LAST : c_MUL_LAST;
                                mcand_q   <= (op_i == c_OP_DIV) ? w_b_mag : w_a_mag;
                                prod_q    <= {{WIDTH{1'b0}}, (op_i == c_OP_DIV) ? w_a_mag : w_b_mag};
                            end
                            c_OP_MTHI: hi_q <= a_i;
                            c_OP_MTLO: lo_q <= a_i;
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (kill_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        prod_q <= (op_q == c_OP_DIV) ? w_prod_div : w_prod_mul;
                        if (cnt_q == '0) begin
                            state_q <= S_FIX;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (!kill_i) begin
                        {hi_q, lo_q} <= w_result;
                        done_q       <= 1'b1;
                        dbz_q        <= (op_q == c_OP_DIV) && bzero_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_iter.sv
// ============================================================================
// tb_muldiv_iter : self-checking bench for muldiv_iter (MUL_BITS 1 and 4)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst1, rst4, start1, start4, kill, op_unsigned;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy1, done1, dbz1, busy4, done4, dbz4;
    logic [31:0] hi1, lo1, hi4, lo4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi[2];
    logic [31:0] m_lo[2];
    logic        m_dbz[2];

    always #5 clk = ~clk;

    muldiv_iter #(.WIDTH(32), .MUL_BITS(1)) u_dut1 (
        .clock_i(clk), .reset_i(rst1), .start_i(start1), .op_i(op),
        .op_unsigned_i(op_unsigned), .a_i(a), .b_i(b), .kill_i(kill),
        .busy_o(busy1), .done_o(done1), .div_by_zero_o(dbz1), .hi_o(hi1), .lo_o(lo1)
    );

    muldiv_iter #(.WIDTH(32), .MUL_BITS(4)) u_dut4 (
        .clock_i(clk), .reset_i(rst4), .start_i(start4), .op_i(op),
        .op_unsigned_i(op_unsigned), .a_i(a), .b_i(b), .kill_i(kill),
        .busy_o(busy4), .done_o(done4), .div_by_zero_o(dbz4), .hi_o(hi4), .lo_o(lo4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one completed op, using plain 64-bit arithmetic
    task automatic model_apply(input int w, input logic [2:0] o, input logic u,
                               input logic [31:0] x, input logic [31:0] y);
        longint      sa, sb, q, r;
        logic [63:0] p, acc;
        sa  = u ? longint'({32'b0, x}) : longint'($signed(x));
        sb  = u ? longint'({32'b0, y}) : longint'($signed(y));
        p   = sa * sb;
        acc = {m_hi[w], m_lo[w]};
        case (o)
            3'd1: acc = p;
            3'd2: acc = acc + p;
            3'd3: acc = acc - p;
            3'd4: begin
                if (y == 32'd0) begin
                    acc = {x, 32'hFFFF_FFFF};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    acc = {r[31:0], q[31:0]};
                end
            end
            3'd5: acc = {x, m_lo[w]};
            3'd6: acc = {m_hi[w], x};
            default: ;
        endcase
        if (o >= 3'd1 && o <= 3'd4) m_dbz[w] = (o == 3'd4) && (y == 32'd0);
        {m_hi[w], m_lo[w]} = acc;
    endtask

    function automatic int exp_lat(input int w, input logic [2:0] o);
        return (o == 3'd4) ? 34 : ((w != 0) ? 10 : 34);
    endfunction

    // Waits (bounded) for done; lat stays 0 if it never comes
    task automatic wait_done(input int w, input int k0, output int lat, output bit busy_bad);
        lat      = 0;
        busy_bad = 1'b0;
        for (int k = k0 + 1; k <= 200; k++) begin
            step();
            start1 = 1'b0; start4 = 1'b0;
            op = 3'($urandom); a = $urandom; b = $urandom; op_unsigned = 1'($urandom);
            if (((w != 0) ? done4 : done1) === 1'b1) begin
                lat = k;
                if (((w != 0) ? busy4 : busy1) !== 1'b0) busy_bad = 1'b1;
                break;
            end
            if (((w != 0) ? busy4 : busy1) !== 1'b1) busy_bad = 1'b1;
        end
    endtask

    task automatic issue(input int w, input logic [2:0] o, input logic u,
                         input logic [31:0] x, input logic [31:0] y,
                         output int lat, output bit busy_bad);
        op = o; op_unsigned = u; a = x; b = y;
        if (w != 0) start4 = 1'b1; else start1 = 1'b1;
        model_apply(w, o, u, x, y);
        wait_done(w, 0, lat, busy_bad);
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst4 = 1'b1; start1 = 1'b0; start4 = 1'b0; kill = 1'b0;
        op = 3'd0; op_unsigned = 1'b0; a = '0; b = '0;
        repeat (3) step();
        rst1 = 1'b0; rst4 = 1'b0;
        for (int w = 0; w < 2; w++) begin m_hi[w] = '0; m_lo[w] = '0; m_dbz[w] = 1'b0; end
        n_checks++; if ({busy1, done1, dbz1} !== 3'b000) begin n_fail++; $display("FAIL reset1 flags: got %b expected 000", {busy1, done1, dbz1}); end
        n_checks++; if ({hi1, lo1} !== 64'd0) begin n_fail++; $display("FAIL reset1 hilo: got %h expected 0", {hi1, lo1}); end
        n_checks++; if ({busy4, done4, dbz4} !== 3'b000) begin n_fail++; $display("FAIL reset4 flags: got %b expected 000", {busy4, done4, dbz4}); end
        n_checks++; if ({hi4, lo4} !== 64'd0) begin n_fail++; $display("FAIL reset4 hilo: got %h expected 0", {hi4, lo4}); end
    endtask

    task automatic test_mul_signed();
        int lat; bit bb;
        issue(0, 3'd1, 1'b0, 32'hFFFF_FFFE, 32'd3, lat, bb);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mul_signed latency: got %0d expected 34", lat); end
        n_checks++; if (bb !== 1'b0) begin n_fail++; $display("FAIL mul_signed busy window: got bad=%0d expected 0", bb); end
        n_checks++; if (hi1 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mul_signed hi: got %h expected ffffffff", hi1); end
        n_checks++; if (lo1 !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mul_signed lo: got %h expected fffffffa", lo1); end
        step();
        n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL mul_signed done pulse: got %b expected 0", done1); end
    endtask

    task automatic test_madd_msub();
        int lat; bit bb;
        op = 3'd5; a = 32'd1; op_unsigned = 1'b0; start1 = 1'b1;
        model_apply(0, 3'd5, 1'b0, 32'd1, 32'd0);
        step(); start1 = 1'b0;
        n_checks++; if ({busy1, done1, hi1} !== {2'b00, 32'd1}) begin n_fail++; $display("FAIL mthi: got busy=%b done=%b hi=%h expected 0 0 1", busy1, done1, hi1); end
        op = 3'd6; a = 32'd5; start1 = 1'b1;
        model_apply(0, 3'd6, 1'b0, 32'd5, 32'd0);
        step(); start1 = 1'b0;
        n_checks++; if ({busy1, done1, lo1} !== {2'b00, 32'd5}) begin n_fail++; $display("FAIL mtlo: got busy=%b done=%b lo=%h expected 0 0 5", busy1, done1, lo1); end
        issue(0, 3'd2, 1'b1, 32'hFFFF_FFFF, 32'd2, lat, bb);
        n_checks++; if ({hi1, lo1} !== 64'h0000_0003_0000_0003) begin n_fail++; $display("FAIL maddu: got %h_%h expected 00000003_00000003", hi1, lo1); end
        issue(0, 3'd3, 1'b0, 32'd1, 32'd3, lat, bb);
        n_checks++; if ({hi1, lo1} !== 64'h0000_0003_0000_0000) begin n_fail++; $display("FAIL msub: got %h_%h expected 00000003_00000000", hi1, lo1); end
        n_checks++; if (lat !== 34 || bb !== 1'b0) begin n_fail++; $display("FAIL msub timing: got lat=%0d bad=%0d expected 34 0", lat, bb); end
    endtask

    task automatic test_div();
        int lat; bit bb;
        issue(0, 3'd4, 1'b0, 32'hFFFF_FFF9, 32'd2, lat, bb);
        n_checks++; if ({hi1, lo1} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_signed: got hi=%h lo=%h expected ffffffff fffffffd", hi1, lo1); end
        n_checks++; if (lat !== 34 || dbz1 !== 1'b0) begin n_fail++; $display("FAIL div_signed timing: got lat=%0d dbz=%b expected 34 0", lat, dbz1); end
        issue(0, 3'd4, 1'b1, 32'd7, 32'd2, lat, bb);
        n_checks++; if ({hi1, lo1} !== {32'd1, 32'd3}) begin n_fail++; $display("FAIL divu: got hi=%h lo=%h expected 1 3", hi1, lo1); end
        issue(0, 3'd4, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, bb);
        n_checks++; if ({hi1, lo1, dbz1} !== {32'd0, 32'h8000_0000, 1'b0}) begin n_fail++; $display("FAIL div_min_m1: got hi=%h lo=%h dbz=%b expected 0 80000000 0", hi1, lo1, dbz1); end
    endtask

    task automatic test_div_by_zero();
        int lat; bit bb;
        issue(0, 3'd4, 1'b1, 32'h0000_1234, 32'd0, lat, bb);
        n_checks++; if ({hi1, lo1} !== {32'h0000_1234, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL dbz result: got hi=%h lo=%h expected 1234 ffffffff", hi1, lo1); end
        n_checks++; if (dbz1 !== 1'b1 || done1 !== 1'b1) begin n_fail++; $display("FAIL dbz flag: got dbz=%b done=%b expected 1 1", dbz1, done1); end
        step();
        n_checks++; if (dbz1 !== 1'b1) begin n_fail++; $display("FAIL dbz hold: got %b expected 1", dbz1); end
        op = 3'd1; op_unsigned = 1'b0; a = $urandom; b = $urandom; start1 = 1'b1;
        model_apply(0, 3'd1, 1'b0, a, b);
        step(); start1 = 1'b0;
        n_checks++; if (dbz1 !== 1'b0) begin n_fail++; $display("FAIL dbz clear: got %b expected 0", dbz1); end
        wait_done(0, 1, lat, bb);
        n_checks++; if (lat !== 34 || {hi1, lo1} !== {m_hi[0], m_lo[0]}) begin n_fail++; $display("FAIL mul after dbz: got lat=%0d %h_%h expected 34 %h_%h", lat, hi1, lo1, m_hi[0], m_lo[0]); end
    endtask

    task automatic test_kill();
        int lat; bit bb, seen;
        logic [31:0] h, l, x, y;
        int kill_at[2] = '{10, 33};
        for (int t = 0; t < 2; t++) begin
            h = m_hi[0]; l = m_lo[0]; seen = 1'b0;
            op = 3'd1; op_unsigned = 1'b0; a = $urandom; b = $urandom; start1 = 1'b1;
            for (int k = 1; k <= kill_at[t]; k++) begin
                step(); start1 = 1'b0;
                if (done1 === 1'b1) seen = 1'b1;
                if (k == kill_at[t]) kill = 1'b1;
            end
            step(); kill = 1'b0;
            n_checks++; if ({seen, busy1, done1} !== 3'b000) begin n_fail++; $display("FAIL kill@%0d flags: got seen=%b busy=%b done=%b expected 000", kill_at[t], seen, busy1, done1); end
            n_checks++; if ({hi1, lo1} !== {h, l}) begin n_fail++; $display("FAIL kill@%0d hilo: got %h_%h expected %h_%h", kill_at[t], hi1, lo1, h, l); end
            x = $urandom; y = $urandom;
            issue(0, 3'd2, 1'b0, x, y, lat, bb);
            n_checks++; if (lat !== 34 || {hi1, lo1} !== {m_hi[0], m_lo[0]}) begin n_fail++; $display("FAIL start after kill: got lat=%0d %h_%h expected 34 %h_%h", lat, hi1, lo1, m_hi[0], m_lo[0]); end
        end
        op = 3'd1; start1 = 1'b1; kill = 1'b1;
        step(); start1 = 1'b0; kill = 1'b0;
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL kill+start idle: got busy=%b expected 0", busy1); end
    endtask

    task automatic test_ignore_busy();
        int lat;
        logic [31:0] x, y;
        x = $urandom; y = $urandom;
        op = 3'd1; op_unsigned = 1'b1; a = x; b = y; start1 = 1'b1;
        model_apply(0, 3'd1, 1'b1, x, y);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            step(); start1 = 1'b0;
            if (k == 5) begin op = 3'd5; a = 32'hDEAD_BEEF; start1 = 1'b1; end
            if (k == 6) begin op = 3'd4; a = 32'd9; b = 32'd0; start1 = 1'b1; end
            if (done1 === 1'b1) begin lat = k; break; end
        end
        n_checks++; if (lat !== 34 || {hi1, lo1, dbz1} !== {m_hi[0], m_lo[0], 1'b0}) begin n_fail++; $display("FAIL start while busy: got lat=%0d %h_%h dbz=%b expected 34 %h_%h 0", lat, hi1, lo1, dbz1, m_hi[0], m_lo[0]); end
        step();
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL start while busy queued: got busy=%b expected 0", busy1); end
    endtask

    task automatic test_mb4();
        int lat; bit bb;
        issue(1, 3'd1, 1'b0, 32'h8000_0000, 32'h8000_0000, lat, bb);
        n_checks++; if (lat !== 10 || bb !== 1'b0) begin n_fail++; $display("FAIL mb4 timing: got lat=%0d bad=%0d expected 10 0", lat, bb); end
        n_checks++; if ({hi4, lo4} !== {32'h4000_0000, 32'd0}) begin n_fail++; $display("FAIL mb4 min*min: got %h_%h expected 40000000_00000000", hi4, lo4); end
        op = 3'd1; op_unsigned = 1'b0; a = $urandom; b = $urandom; start4 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(); start4 = 1'b0;
            if (k == 5) rst4 = 1'b1;
        end
        step(); rst4 = 1'b0;
        m_hi[1] = '0; m_lo[1] = '0; m_dbz[1] = 1'b0;
        n_checks++; if ({busy4, done4, hi4, lo4} !== 66'd0) begin n_fail++; $display("FAIL mb4 reset mid-op: got busy=%b done=%b %h_%h expected all 0", busy4, done4, hi4, lo4); end
    endtask

    task automatic test_random();
        int w, lat; bit bb, u;
        logic [2:0]  o;
        logic [31:0] x, y, gh, gl;
        logic        gd, gb;
        for (int i = 0; i < 48; i++) begin
            w = $urandom_range(0, 1);
            o = 3'($urandom_range(1, 6));
            u = 1'($urandom); x = $urandom; y = $urandom;
            case ($urandom_range(0, 7))
                0: x = 32'h8000_0000;
                1: y = 32'hFFFF_FFFF;
                2: y = 32'd0;
                3: y = $urandom_range(1, 16);
                default: ;
            endcase
            if (y == 32'd0) u = 1'b1;
            if (o >= 3'd5) begin
                op = o; op_unsigned = u; a = x; b = y;
                if (w != 0) start4 = 1'b1; else start1 = 1'b1;
                model_apply(w, o, u, x, y);
                step(); start1 = 1'b0; start4 = 1'b0;
                gb = (w != 0) ? busy4 : busy1;
                gh = (w != 0) ? hi4 : hi1; gl = (w != 0) ? lo4 : lo1;
                n_checks++; if ({gb, gh, gl} !== {1'b0, m_hi[w], m_lo[w]}) begin n_fail++; $display("FAIL rand%0d mt%0d dut%0d: got busy=%b %h_%h expected 0 %h_%h", i, o, w, gb, gh, gl, m_hi[w], m_lo[w]); end
            end else begin
                issue(w, o, u, x, y, lat, bb);
                gh = (w != 0) ? hi4 : hi1; gl = (w != 0) ? lo4 : lo1;
                gd = (w != 0) ? dbz4 : dbz1;
                n_checks++; if (lat !== exp_lat(w, o) || bb !== 1'b0) begin n_fail++; $display("FAIL rand%0d timing op%0d dut%0d: got lat=%0d bad=%0d expected %0d 0", i, o, w, lat, bb, exp_lat(w, o)); end
                n_checks++; if ({gh, gl, gd} !== {m_hi[w], m_lo[w], m_dbz[w]}) begin n_fail++; $display("FAIL rand%0d op%0d u%0d a=%h b=%h dut%0d: got %h_%h dbz=%b expected %h_%h dbz=%b", i, o, u, x, y, w, gh, gl, gd, m_hi[w], m_lo[w], m_dbz[w]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_signed();
        test_madd_msub();
        test_div();
        test_div_by_zero();
        test_kill();
        test_ignore_busy();
        test_mb4();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative multiply/divide unit with HI/LO result registers.
- Successor to the single-cycle behavioural mul/div logic in the execute stage. It replaces the unsynthesisable `*`, `/` and `%` operators with a shift-add multiplier and a restoring divider.
- Parametrised in operand width and multiplier radix. Adds a start/busy/done handshake, kill, MSUB and divide-by-zero reporting.
- Sits beside the ALU in EX. EX stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (even, >=8).
- MUL_BITS, 1, multiplier bits retired per cycle (1, 2 or 4; must divide WIDTH).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- op  in  3  0 NOP, 1 MUL, 2 MADD, 3 MSUB, 4 DIV, 5 MTHI, 6 MTLO, 7 NOP
- op_unsigned  in  1  1 = unsigned operands
- a  in  WIDTH  multiplicand / dividend / MTHI-MTLO source
- b  in  WIDTH  multiplier / divisor
- kill  in  1  abort in-flight op (pipeline flush)
- busy  out  WIDTH-independent 1  op in flight; EX must stall
- done  out  1  one-cycle pulse; hi/lo show the new result this cycle
- div_by_zero  out  1  valid with done; last DIV had b==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0. Reset mid-operation aborts and zeroes hi/lo.
- States:
  - IDLE: start && op in {1,2,3,4} -> CALC. Latch |a|, |b| (raw values if op_unsigned), the result sign, the op, and whether b==0.
  - CALC: counter runs N cycles, then -> FIX. N = WIDTH/MUL_BITS for MUL/MADD/MSUB; N = WIDTH for DIV.
  - FIX: apply sign fix-up and accumulate, write hi/lo, pulse done -> IDLE.
- MTHI/MTLO in IDLE: single-cycle. hi (or lo) <= a at that edge; no busy, no done. NOP and op 7 do nothing.
- Latency: accept in cycle c0. busy=1 in c1..c(N+1). done=1 in c(N+2) with busy=0. A new start is accepted in c(N+2).
- Example: WIDTH=32, MUL_BITS=1 gives done 34 cycles after accept.
- start while busy=1 is ignored (not queued). a, b and op_unsigned are not required to be held after c0.
- Multiply: 2*WIDTH-bit product P. Signed mode uses magnitudes and negates P if the operand signs differ.
  - MUL: {hi,lo} <= P.
  - MADD: {hi,lo} <= {hi,lo} + P.
  - MSUB: {hi,lo} <= {hi,lo} - P.
  - All modulo 2^(2*WIDTH). The accumulate uses hi/lo as held at FIX; they cannot change while busy.
- Divide: restoring, 1 quotient bit per cycle on magnitudes.
  - Signed fix-up: quotient negated if the signs differ; remainder takes the sign of a.
  - Result: lo <= quotient, hi <= remainder.
  - Signed MIN / -1: lo = MIN, hi = 0, no flag.
- Divide by zero: fix-up bypassed; lo <= all ones, hi <= a (as latched); div_by_zero=1 with done. div_by_zero clears on the next accepted start.
- kill: in CALC or FIX -> IDLE next edge. hi/lo unchanged, no done, busy=0 next cycle. kill in IDLE has no effect. kill and start in the same IDLE cycle: kill wins, nothing accepted.
- reset has priority over kill, which has priority over start.

Test Plan:
- MUL signed, a=0xFFFFFFFE (-2), b=3 -> done in c34, busy high c1..c33, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MTHI a=1, MTLO a=5, then MADDU a=0xFFFFFFFF, b=2 -> hi=0x00000003, lo=0x00000003. Then MSUB signed a=1, b=3 -> hi=0x00000003, lo=0x00000000.
- DIV signed a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2 -> lo=3, hi=1.
- DIV b=0, a=0x1234 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1. Next MUL accepted -> div_by_zero=0.
- MUL with kill asserted in c10 -> busy=0 from c11, no done, hi/lo keep prior values. start in c11 is accepted.
- MUL_BITS=4: MUL 0x80000000 * 0x80000000 signed -> done in c10, hi=0x40000000, lo=0. Assert reset in c5 of a fresh op -> hi=lo=0, busy=0 next cycle.
